// File: rtl/weight_tile_loader.sv
// -----------------------------------------------------------------------------
// weight_tile_loader
//
// Fetches one complete weight buffer from memory and writes it into a target
// buffer, one tile at a time. Each tile is assembled from BEATS single-beat
// reads, with the first beat placed in the least significant bits. Beat
// addresses increase by MEM_DATA_WIDTH/8 bytes and wrap modulo 2^ADDR_WIDTH.
// Only one memory request is ever outstanding.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               one-cycle load command (ignored while busy)
//   base_addr           byte address of the first beat
//   dest_buffer         target buffer index, latched on start
//   busy                load in progress (any state other than IDLE)
//   done                one-cycle completion pulse
//   error               sticky protocol error: unexpected mem_rvalid or
//                       writing_done; cleared by reset or an accepted start
//   mem_req / mem_addr  read request and byte address, held until mem_gnt
//   mem_gnt             request accepted
//   mem_rvalid/mem_rdata read data return
//   write_enable        one-cycle tile write strobe
//   write_data          assembled tile
//   write_buffer        buffer index for the write
//   writing_done        buffer reports that the last tile is stored
// -----------------------------------------------------------------------------
module weight_tile_loader #(
    parameter int BUFFER_WIDTH   = 1024,
    parameter int BUFFER_COUNT   = 2,
    parameter int TILE_WIDTH     = 256,
    parameter int MEM_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH     = 24
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic [ADDR_WIDTH-1:0]           base_addr,
    input  logic [$clog2(BUFFER_COUNT)-1:0] dest_buffer,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic                            mem_req,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    input  logic                            mem_gnt,
    input  logic                            mem_rvalid,
    input  logic [MEM_DATA_WIDTH-1:0]       mem_rdata,
    output logic                            write_enable,
    output logic [TILE_WIDTH-1:0]           write_data,
    output logic [$clog2(BUFFER_COUNT)-1:0] write_buffer,
    input  logic                            writing_done
);

    localparam int BEATS  = TILE_WIDTH / MEM_DATA_WIDTH;
    localparam int TILES  = BUFFER_WIDTH / TILE_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TILE_W = (TILES > 1) ? $clog2(TILES) : 1;
    localparam int BUF_W  = $clog2(BUFFER_COUNT);

    localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [TILE_W-1:0]     LAST_TILE = TILE_W'(TILES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(MEM_DATA_WIDTH / 8);

    // Reject geometries that do not divide into whole beats and tiles.
    if ((BEATS < 1) || (TILES < 1) ||
        ((TILE_WIDTH % MEM_DATA_WIDTH) != 0) ||
        ((BUFFER_WIDTH % TILE_WIDTH) != 0) ||
        ((MEM_DATA_WIDTH % 8) != 0) ||
        (BUFFER_COUNT < 2)) begin : g_param_check
        $error("weight_tile_loader: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ       = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_WRITE     = 3'd3,
        ST_WAIT_DONE = 3'd4
    } state_t;

    state_t                  state_r;
    logic [BEAT_W-1:0]       beat_r;
    logic [TILE_W-1:0]       tile_r;
    logic [TILE_WIDTH-1:0]   asm_r;
    logic [TILE_WIDTH-1:0]   asm_next_s;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    mem_req_r;
    logic                    write_enable_r;
    logic [TILE_WIDTH-1:0]   write_data_r;
    logic [BUF_W-1:0]        write_buffer_r;
    logic                    done_r;
    logic                    error_r;
    logic                    spurious_s;

    // Tile under assembly with the current beat merged in at its slot.
    always_comb begin
        asm_next_s = asm_r;
        asm_next_s[int'(beat_r) * MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_rdata;
    end

    // Protocol events that arrive in a state that does not expect them.
    always_comb begin
        if (((mem_rvalid == 1'b1) && (state_r != ST_WAIT_DATA)) ||
            ((writing_done == 1'b1) && (state_r != ST_WAIT_DONE))) begin
            spurious_s = 1'b1;
        end else begin
            spurious_s = 1'b0;
        end
    end

    // Load sequencer: state, counters, address, assembly and all outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            beat_r         <= '0;
            tile_r         <= '0;
            asm_r          <= '0;
            addr_r         <= '0;
            mem_req_r      <= 1'b0;
            write_enable_r <= 1'b0;
            write_data_r   <= '0;
            write_buffer_r <= '0;
            done_r         <= 1'b0;
            error_r        <= 1'b0;
        end else begin
            done_r         <= 1'b0;
            write_enable_r <= 1'b0;
            if (spurious_s) begin
                error_r <= 1'b1;
            end else begin
                error_r <= error_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        addr_r         <= base_addr;
                        write_buffer_r <= dest_buffer;
                        beat_r         <= '0;
                        tile_r         <= '0;
                        // An accepted start clears the error unless a new
                        // spurious event lands in this very cycle.
                        error_r        <= spurious_s;
                        mem_req_r      <= 1'b1;
                        state_r        <= ST_REQ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req_r <= 1'b0;
                        state_r   <= ST_WAIT_DATA;
                    end else begin
                        mem_req_r <= 1'b1;
                        state_r   <= ST_REQ;
                    end
                end

                ST_WAIT_DATA: begin
                    if (mem_rvalid) begin
                        asm_r  <= asm_next_s;
                        addr_r <= addr_r + ADDR_STEP;
                        if (beat_r == LAST_BEAT) begin
                            beat_r         <= '0;
                            write_enable_r <= 1'b1;
                            write_data_r   <= asm_next_s;
                            state_r        <= ST_WRITE;
                        end else begin
                            beat_r    <= beat_r + BEAT_W'(1);
                            mem_req_r <= 1'b1;
                            state_r   <= ST_REQ;
                        end
                    end else begin
                        state_r <= ST_WAIT_DATA;
                    end
                end

                ST_WRITE: begin
                    if (tile_r == LAST_TILE) begin
                        state_r <= ST_WAIT_DONE;
                    end else begin
                        tile_r    <= tile_r + TILE_W'(1);
                        mem_req_r <= 1'b1;
                        state_r   <= ST_REQ;
                    end
                end

                ST_WAIT_DONE: begin
                    if (writing_done) begin
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT_DONE;
                    end
                end

                default: begin
                    mem_req_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy         = (state_r != ST_IDLE);
    assign done         = done_r;
    assign error        = error_r;
    assign mem_req      = mem_req_r;
    assign mem_addr     = addr_r;
    assign write_enable = write_enable_r;
    assign write_data   = write_data_r;
    assign write_buffer = write_buffer_r;

endmodule
